// File: rtl/period_generator.sv
// Programmable square-wave generator: emits `cycles` periods of `prd` ms at 50% duty, then pulses done_tick.
// Latency: accepted start at clock k -> so=1 from k+1; last LOW clock m -> done_tick at m+1, ready at m+2.
// Backpressure: none; start is honoured only while ready=1, and stop lets the current period finish.
module period_generator #(
   parameter int CLK_MS_COUNT = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic [9:0] prd,
   input  logic [7:0] cycles,
   output logic       so,
   output logic       ready,
   output logic       done_tick
);

   localparam int HALF_MS = CLK_MS_COUNT / 2;
   // Keep the half-ms counter at least one bit wide even for the smallest legal CLK_MS_COUNT.
   localparam int TW = (HALF_MS > 1) ? $clog2(HALF_MS) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(HALF_MS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_n;
   logic [TW-1:0]   t_q;
   logic [9:0]      h_q;
   logic [7:0]      c_q;
   logic [9:0]      prd_r;
   logic [7:0]      cyc_r;
   logic            stop_pend;

   logic            start_ok;
   logic            half_end;
   logic            phase_end;
   logic            last_period;

   // Zero prd/cycles are rejected here, so prd_r-1 and cyc_r-1 below can never underflow.
   assign start_ok    = (prd != 10'd0) && (cycles != 8'd0);
   assign half_end    = (t_q == T_LAST);
   assign phase_end   = half_end && (h_q == prd_r - 10'd1);
   assign last_period = (c_q == cyc_r - 8'd1) || stop_pend;

   // Next-state and status outputs; ready/done_tick decode straight from the state.
   always_comb begin
      state_n   = state_q;
      ready     = 1'b0;
      done_tick = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) state_n = start_ok ? HIGH : DONE;
         end
         HIGH: begin
            if (phase_end) state_n = LOW;
         end
         LOW: begin
            if (phase_end) state_n = last_period ? DONE : HIGH;
         end
         DONE: begin
            done_tick = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State, output register and the t/h/c timing counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         so        <= 1'b0;
         t_q       <= '0;
         h_q       <= '0;
         c_q       <= '0;
         prd_r     <= '0;
         cyc_r     <= '0;
         stop_pend <= 1'b0;
      end else begin
         state_q <= state_n;
         // so follows the state we are entering, so it changes on the same edge as the FSM.
         so      <= (state_n == HIGH);
         case (state_q)
            IDLE: begin
               if (start && start_ok) begin
                  prd_r     <= prd;
                  cyc_r     <= cycles;
                  t_q       <= '0;
                  h_q       <= '0;
                  c_q       <= '0;
                  stop_pend <= 1'b0;
               end
            end
            HIGH, LOW: begin
               if (stop) stop_pend <= 1'b1;
               if (half_end) begin
                  t_q <= '0;
                  h_q <= (h_q == prd_r - 10'd1) ? 10'd0 : h_q + 10'd1;
               end else begin
                  t_q <= t_q + TW'(1);
               end
               if (state_q == LOW && phase_end && !last_period) c_q <= c_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_period_generator.sv
// Self-checking bench for period_generator with CLK_MS_COUNT=10 (half-ms = 5 clocks).
// Latency: outputs of cycle n are sampled after the edge that starts cycle n.
// Backpressure: n/a; stimulus is directed runs followed by randomized start/stop/reset traffic.
module tb_period_generator;

   localparam int CMS = 10;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic [9:0] prd;
   logic [7:0] cycles;
   logic       so;
   logic       ready;
   logic       done_tick;

   int tests = 0;
   int fails = 0;
   int n     = 0;
   bit chk_en = 0;

   // Reference model: the current run is described by its start cycle, period in ms
   // and the number of periods that will actually be emitted.
   bit has_run  = 0;
   bit rst_pend = 0;
   int m_k      = 0;
   int m_p      = 0;
   int m_m      = 0;

   logic so_log  [0:127];
   logic rdy_log [0:127];
   logic dn_log  [0:127];

   period_generator #(.CLK_MS_COUNT(CMS)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .prd       (prd),
      .cycles    (cycles),
      .so        (so),
      .ready     (ready),
      .done_tick (done_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {so, ready, done_tick} for cycle m.
   function automatic logic [2:0] model_out(input int m);
      int r;
      int len;
      if (!has_run) return 3'b010;
      r   = m - m_k;
      len = m_p * CMS;
      if (r <= 0) return 3'b010;
      if (r <= m_m * len) return {(((r - 1) % len) < (len / 2)), 2'b00};
      if (r == m_m * len + 1) return 3'b001;
      return 3'b010;
   endfunction

   function automatic bit model_busy(input int m);
      int r;
      if (!has_run) return 1'b0;
      r = m - m_k;
      return (r >= 1) && (r <= m_m * m_p * CMS);
   endfunction

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Drive inputs for the current cycle, advance the model, then move to the next cycle.
   task automatic step(input logic st, input logic sp, input logic [9:0] p,
                       input logic [7:0] cy, input logic rs);
      logic [2:0] cur;
      int         r;
      int         nm;
      start  = st;
      stop   = sp;
      prd    = p;
      cycles = cy;
      reset  = rs;
      cur    = model_out(n);
      if (rs) begin
         rst_pend = 1'b1;
      end else if (st && cur[1]) begin
         has_run = 1'b1;
         m_k     = n;
         m_p     = int'(p);
         m_m     = (p == 10'd0 || cy == 8'd0) ? 0 : int'(cy);
      end else if (sp && model_busy(n)) begin
         // A stop seen in the last clock of a period is only registered for the next one.
         r  = n - m_k;
         nm = r / (m_p * CMS) + 1;
         if (nm < m_m) m_m = nm;
      end
      @(posedge clk);
      n++;
      #1;
      if (rst_pend) begin
         has_run  = 1'b0;
         rst_pend = 1'b0;
      end
   endtask

   // Start a run and log the outputs of its first `len` cycles (index = clocks after start).
   task automatic run_rec(input logic [9:0] p, input logic [7:0] cy, input int stop_r,
                          input bit chg, input int len);
      step(1'b1, 1'b0, p, cy, 1'b0);
      for (int r = 1; r <= len; r++) begin
         so_log[r]  = so;
         rdy_log[r] = ready;
         dn_log[r]  = done_tick;
         step(chg && (r % 7 == 3), r == stop_r, chg ? 10'd7 : p, chg ? 8'd9 : cy, 1'b0);
      end
   endtask

   // Every cycle after the first reset: DUT outputs must match the model.
   always @(negedge clk) begin
      logic [2:0] e;
      if (chk_en) begin
         e = model_out(n);
         tests++;
         if ({so, ready, done_tick} !== e) begin
            fails++;
            $display("FAIL model cycle %0d: so/ready/done got %b%b%b expected %b", n, so, ready, done_tick, e);
         end
      end
   end

   initial begin
      logic       st;
      logic       sp;
      logic       rs;
      logic [9:0] p;
      logic [7:0] cy;
      start = 0; stop = 0; prd = '0; cycles = '0; reset = 1;

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0, 8'd0, 1'b1);
      chk_en = 1;
      lit("reset so", {31'd0, so}, 0);
      lit("reset ready", {31'd0, ready}, 1);
      lit("reset done", {31'd0, done_tick}, 0);

      // Reset in the middle of HIGH.
      step(1'b1, 1'b0, 10'd3, 8'd2, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'd3, 8'd2, 1'b0);
      lit("midhigh so", {31'd0, so}, 1);
      step(1'b0, 1'b0, 10'd3, 8'd2, 1'b1);
      lit("rst so", {31'd0, so}, 0);
      lit("rst ready", {31'd0, ready}, 1);
      lit("rst done", {31'd0, done_tick}, 0);

      // prd=3, cycles=2.
      run_rec(10'd3, 8'd2, 0, 1'b0, 63);
      lit("p3 so@1", {31'd0, so_log[1]}, 1);
      lit("p3 so@15", {31'd0, so_log[15]}, 1);
      lit("p3 so@16", {31'd0, so_log[16]}, 0);
      lit("p3 so@30", {31'd0, so_log[30]}, 0);
      lit("p3 so@31", {31'd0, so_log[31]}, 1);
      lit("p3 so@46", {31'd0, so_log[46]}, 0);
      lit("p3 done@60", {31'd0, dn_log[60]}, 0);
      lit("p3 done@61", {31'd0, dn_log[61]}, 1);
      lit("p3 ready@61", {31'd0, rdy_log[61]}, 0);
      lit("p3 ready@62", {31'd0, rdy_log[62]}, 1);

      // prd=1, cycles=1.
      run_rec(10'd1, 8'd1, 0, 1'b0, 12);
      lit("p1 so@5", {31'd0, so_log[5]}, 1);
      lit("p1 so@6", {31'd0, so_log[6]}, 0);
      lit("p1 done@11", {31'd0, dn_log[11]}, 1);
      lit("p1 ready@12", {31'd0, rdy_log[12]}, 1);

      // Zero period or zero count: straight to DONE.
      run_rec(10'd0, 8'd4, 0, 1'b0, 3);
      lit("p0 so@1", {31'd0, so_log[1]}, 0);
      lit("p0 done@1", {31'd0, dn_log[1]}, 1);
      lit("p0 ready@2", {31'd0, rdy_log[2]}, 1);
      run_rec(10'd5, 8'd0, 0, 1'b0, 3);
      lit("c0 done@1", {31'd0, dn_log[1]}, 1);
      lit("c0 so@2", {31'd0, so_log[2]}, 0);

      // Stop early in a long run: exactly one full period.
      run_rec(10'd2, 8'd255, 3, 1'b0, 23);
      lit("stop so@10", {31'd0, so_log[10]}, 1);
      lit("stop so@11", {31'd0, so_log[11]}, 0);
      lit("stop done@20", {31'd0, dn_log[20]}, 0);
      lit("stop done@21", {31'd0, dn_log[21]}, 1);
      lit("stop ready@22", {31'd0, rdy_log[22]}, 1);

      // Start re-pulsed and inputs changed while busy.
      run_rec(10'd2, 8'd2, 0, 1'b1, 42);
      lit("chg so@21", {31'd0, so_log[21]}, 1);
      lit("chg so@31", {31'd0, so_log[31]}, 0);
      lit("chg done@41", {31'd0, dn_log[41]}, 1);
      lit("chg ready@42", {31'd0, rdy_log[42]}, 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         st = ($urandom_range(0, 7) == 0);
         sp = ($urandom_range(0, 29) == 0);
         rs = ($urandom_range(0, 399) == 0);
         p  = 10'($urandom_range(0, 4));
         cy = 8'($urandom_range(0, 3));
         step(st, sp, p, cy, rs);
      end

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
